jk_cmd_sequencer: RTL

//   Upstream driver stage for the JK latch. Accepts {J,K} commands over a valid/ready

---
 rtl/jk_cmd_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/jk_cmd_sequencer.sv
// JK latch driver: buffers {J,K} commands and replays each one as a
// setup / enable pulse / hold / gap sequence, tracking the expected Q.
module jk_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1,
  localparam int LW     = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  input  logic [1:0]    cmd,
  output logic          cmd_ready,
  output logic          J,
  output logic          K,
  output logic          enable,
  output logic          q_exp,
  output logic          cmd_done,
  output logic          busy,
  output logic [LW-1:0] level
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CMAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    GAP
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    cur, cur_n;
  logic          j_n, k_n, en_n;
  logic          done_n, q_n;

  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [1:0]    head;
  logic          push, pop;
  logic          full, empty;
  logic [CW-1:0] plen_m1;

  assign full      = (level == LW'(DEPTH));
  assign empty     = (level == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign head      = mem[rd_ptr];
  assign busy      = (state != IDLE) || !empty;

  // toggle gets a single enable cycle so the latch cannot race
  assign plen_m1 = (cur == 2'b11) ? '0 : CW'(PULSE_W - 1);

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= cmd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      cur      <= '0;
      J        <= 1'b0;
      K        <= 1'b0;
      enable   <= 1'b0;
      cmd_done <= 1'b0;
      q_exp    <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      cur      <= cur_n;
      J        <= j_n;
      K        <= k_n;
      enable   <= en_n;
      cmd_done <= done_n;
      q_exp    <= q_n;
    end
  end

  // outputs are computed for the next state and registered
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cur_n   = cur;
    j_n     = 1'b0;
    k_n     = 1'b0;
    en_n    = 1'b0;
    done_n  = 1'b0;
    q_n     = q_exp;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          cur_n   = head;
          {j_n, k_n} = head;
          state_n = SETUP;
        end
      end
      SETUP: begin
        {j_n, k_n} = cur;
        en_n    = 1'b1;
        cnt_n   = plen_m1;
        state_n = PULSE;
      end
      PULSE: begin
        {j_n, k_n} = cur;
        if (cnt == '0) begin
          done_n  = 1'b1;
          state_n = HOLD;
          unique case (cur)
            2'b01:   q_n = 1'b0;
            2'b10:   q_n = 1'b1;
            2'b11:   q_n = ~q_exp;
            default: q_n = q_exp;
          endcase
        end else begin
          en_n  = 1'b1;
          cnt_n = cnt - CW'(1);
        end
      end
      HOLD: begin
        cnt_n   = CW'(GAP_W - 1);
        state_n = GAP;
      end
      GAP: begin
        if (cnt != '0) begin
          cnt_n = cnt - CW'(1);
        end else if (!empty) begin
          pop     = 1'b1;
          cur_n   = head;
          {j_n, k_n} = head;
          state_n = SETUP;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
